clip_share_sched: RTL and testbench

CLIP_SHARE_SCHED -- requirements
Module: clip_share_sched

---
 rtl/clip_sched_pkg.sv | 10 +
 rtl/clip_sat.sv | 26 ++
 rtl/clip_share_sched.sv | 100 ++++++++++
 tb/tb_clip_share_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/clip_sched_pkg.sv
// Shared widths, channel-index width and saturation bounds for the clip/share scheduler.
// Pure constants, no logic.
package clip_sched_pkg;
    localparam int NCH_DEF      = 4;
    localparam int BITS_IN_DEF  = 24;
    localparam int BITS_OUT_DEF = 16;
    localparam int CHW          = 3;
    localparam int SAT_MAX_DEF  = (1 << (BITS_OUT_DEF - 1)) - 1;
    localparam int SAT_MIN_DEF  = -(1 << (BITS_OUT_DEF - 1));
endpackage

// File: rtl/clip_sat.sv
// Signed saturation from BITS_IN down to BITS_OUT; purely combinational, no flow control.
module clip_sat #(
    parameter int BITS_IN  = 24,
    parameter int BITS_OUT = 16
) (
    input  logic [BITS_IN-1:0]  in,
    output logic [BITS_OUT-1:0] out,
    output logic                clipped
);
    localparam int HW = BITS_IN - BITS_OUT + 1;
    localparam logic [BITS_OUT-1:0] MAXV = {1'b0, {(BITS_OUT-1){1'b1}}};
    localparam logic [BITS_OUT-1:0] MINV = {1'b1, {(BITS_OUT-1){1'b0}}};

    logic [HW-1:0] head;
    assign head = in[BITS_IN-1:BITS_OUT-1];

    // The value fits exactly when every dropped bit equals the new sign bit.
    always_comb begin
        out     = in[BITS_OUT-1:0];
        clipped = 1'b0;
        if (head != {HW{1'b0}} && head != {HW{1'b1}}) begin
            clipped = 1'b1;
            out     = in[BITS_IN-1] ? MINV : MAXV;
        end
    end
endmodule

// File: rtl/clip_share_sched.sv
// Round-robin sharing of one saturating clipper across NCH single-slot channels.
// Output registered one cycle after grant; no backpressure, a re-strobed pending slot overwrites and flags overrun.
module clip_share_sched
    import clip_sched_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int BITS_IN  = BITS_IN_DEF,
    parameter int BITS_OUT = BITS_OUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NCH*BITS_IN-1:0] in_data,
    input  logic [NCH-1:0]         in_strobe,
    output logic [BITS_OUT-1:0]    out_data,
    output logic                   out_strobe,
    output logic [2:0]             out_chan,
    output logic                   out_clipped,
    input  logic                   ovr_clr,
    output logic [NCH-1:0]         ovr
);
    logic [NCH-1:0]     slot_vld;
    logic [BITS_IN-1:0] slot_dat [NCH];
    logic [CHW-1:0]     last_grant;

    logic [7:0]          vld_ext;
    logic [CHW:0]        cand;
    logic                grant_vld;
    logic [CHW-1:0]      grant_idx;
    logic [BITS_IN-1:0]  sel_dat;
    logic [BITS_OUT-1:0] sat_dat;
    logic                sat_clip;

    assign vld_ext = 8'(slot_vld);

    // Search starts one past the last grant and wraps modulo NCH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, last_grant} + (CHW+1)'(i);
            if (cand >= (CHW+1)'(NCH))
                cand = cand - (CHW+1)'(NCH);
            if (en && !grant_vld && vld_ext[cand[CHW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[CHW-1:0];
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NCH; k++)
            if (grant_idx == CHW'(k))
                sel_dat = slot_dat[k];
    end

    clip_sat #(
        .BITS_IN  (BITS_IN),
        .BITS_OUT (BITS_OUT)
    ) u_sat (
        .in      (sel_dat),
        .out     (sat_dat),
        .clipped (sat_clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld    <= '0;
            for (int k = 0; k < NCH; k++)
                slot_dat[k] <= '0;
            ovr         <= '0;
            last_grant  <= CHW'(NCH - 1);
            out_strobe  <= 1'b0;
            out_data    <= '0;
            out_chan    <= '0;
            out_clipped <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                // A strobe on the grant cycle reloads the slot; only a non-granted valid slot overruns.
                if (in_strobe[k]) begin
                    slot_dat[k] <= in_data[k*BITS_IN +: BITS_IN];
                    slot_vld[k] <= 1'b1;
                end else if (grant_vld && grant_idx == CHW'(k)) begin
                    slot_vld[k] <= 1'b0;
                end
                ovr[k] <= (ovr[k] & ~ovr_clr) |
                          (in_strobe[k] & slot_vld[k] & ~(grant_vld && grant_idx == CHW'(k)));
            end
            out_strobe <= grant_vld;
            if (grant_vld) begin
                last_grant  <= grant_idx;
                out_data    <= sat_dat;
                out_chan    <= grant_idx;
                out_clipped <= sat_clip;
            end
        end
    end
endmodule

// File: tb/tb_clip_share_sched.sv
// Directed bench for clip_share_sched with default parameters (4 channels, 24 -> 16 bits).
module tb_clip_share_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [95:0] in_data;
    logic [3:0]  in_strobe;
    logic [15:0] out_data;
    logic        out_strobe;
    logic [2:0]  out_chan;
    logic        out_clipped;
    logic        ovr_clr;
    logic [3:0]  ovr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clip_share_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_data     (in_data),
        .in_strobe   (in_strobe),
        .out_data    (out_data),
        .out_strobe  (out_strobe),
        .out_chan    (out_chan),
        .out_clipped (out_clipped),
        .ovr_clr     (ovr_clr),
        .ovr         (ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [23:0] d);
        in_data[ch*24 +: 24] = d;
        in_strobe[ch]        = 1'b1;
    endtask

    task automatic expect_out(input string tag, input int ch, input logic [15:0] d, input logic clp);
        chk({tag, "_stb"}, 32'(out_strobe), 32'd1);
        chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_clip"}, 32'(out_clipped), 32'(clp));
    endtask

    typedef struct {
        int          ch;
        logic [23:0] din;
        logic [15:0] dout;
        logic        clp;
    } vec_t;

    vec_t vecs [7] = '{
        '{1, 24'h012345, 16'h7FFF, 1'b1},
        '{2, 24'hFF0000, 16'h8000, 1'b1},
        '{3, 24'hFFFF80, 16'hFF80, 1'b0},
        '{0, 24'h007FFF, 16'h7FFF, 1'b0},
        '{1, 24'h008000, 16'h7FFF, 1'b1},
        '{2, 24'hFF8000, 16'h8000, 1'b0},
        '{3, 24'hFF7FFF, 16'h8000, 1'b1}
    };

    initial begin
        rst_n = 1'b0; en = 1'b1; in_data = '0; in_strobe = '0; ovr_clr = 1'b0;
        #12;
        chk("rst_stb",  32'(out_strobe),  32'd0);
        chk("rst_data", 32'(out_data),    32'd0);
        chk("rst_chan", 32'(out_chan),    32'd0);
        chk("rst_clip", 32'(out_clipped), 32'd0);
        chk("rst_ovr",  32'(ovr),         32'd0);
        rst_n = 1'b1;
        tick();

        // pass-through, two-cycle latency
        put(0, 24'h000100);
        tick(); in_strobe = '0;
        chk("pass_early", 32'(out_strobe), 32'd0);
        tick();
        expect_out("pass", 0, 16'h0100, 1'b0);
        tick();
        chk("idle_stb",  32'(out_strobe), 32'd0);
        chk("idle_hold", 32'(out_data),   32'h0100);

        // saturation table; ends with last grant on channel 3
        foreach (vecs[i]) begin
            put(vecs[i].ch, vecs[i].din);
            tick(); in_strobe = '0;
            tick();
            expect_out($sformatf("sat%0d", i), vecs[i].ch, vecs[i].dout, vecs[i].clp);
        end

        // fairness: two simultaneous bursts
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) put(k, 24'(k * 16 + 5 + b * 256));
            tick(); in_strobe = '0;
            for (int k = 0; k < 4; k++) begin
                tick();
                expect_out($sformatf("rr%0d_%0d", b, k), k, 16'(k * 16 + 5 + b * 256), 1'b0);
            end
            tick();
            chk($sformatf("rr%0d_end", b), 32'(out_strobe), 32'd0);
        end

        // overrun while frozen
        en = 1'b0;
        put(3, 24'h000010); tick(); in_strobe = '0;
        put(3, 24'h000020); tick(); in_strobe = '0;
        chk("ovr_set", 32'(ovr), 32'b1000);
        tick();
        chk("frozen_stb", 32'(out_strobe), 32'd0);
        en = 1'b1;
        tick();
        expect_out("ovr_out", 3, 16'h0020, 1'b0);
        tick();
        chk("ovr_single", 32'(out_strobe), 32'd0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'd0);

        // a new overrun coinciding with a clear still sets
        en = 1'b0;
        put(2, 24'h000050); tick(); in_strobe = '0;
        put(2, 24'h000060); tick(); in_strobe = '0;
        put(1, 24'h000030); tick(); in_strobe = '0;
        put(1, 24'h000040); ovr_clr = 1'b1; tick(); in_strobe = '0; ovr_clr = 1'b0;
        chk("set_wins", 32'(ovr), 32'b0010);
        en = 1'b1;
        tick(); expect_out("sw_a", 1, 16'h0040, 1'b0);
        tick(); expect_out("sw_b", 2, 16'h0060, 1'b0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

        // same-cycle reload of the granted slot
        put(0, 24'h000111); tick();
        put(0, 24'h000222); tick(); in_strobe = '0;
        expect_out("reload_a", 0, 16'h0111, 1'b0);
        tick();
        expect_out("reload_b", 0, 16'h0222, 1'b0);
        chk("reload_ovr", 32'(ovr), 32'd0);

        // reset with three slots pending
        en = 1'b0;
        put(1, 24'h000001); tick(); in_strobe = '0;
        put(1, 24'h000002); put(2, 24'h000003); put(3, 24'h000004); tick(); in_strobe = '0;
        chk("pre_rst_ovr", 32'(ovr), 32'b0010);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ovr",  32'(ovr),      32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        #3;
        rst_n = 1'b1;
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_rst_idle%0d", c), 32'(out_strobe), 32'd0);
        end
        put(0, 24'h000AAA); put(1, 24'h000BBB); tick(); in_strobe = '0;
        tick(); expect_out("post_rst_a", 0, 16'h0AAA, 1'b0);
        tick(); expect_out("post_rst_b", 1, 16'h0BBB, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
